// File: rtl/cs147_control_unit_if.sv
// Bus between the cs147 control unit and the memory model / datapath.
// master: the control unit (drives IR, control word and memory strobes).
// slave:  the surrounding processor (supplies ZERO and memory read data).
interface cs147_control_unit_if;
    logic        zero;
    logic [31:0] mem_data;
    logic [31:0] instruction;
    logic [31:0] ctrl;
    logic        read;
    logic        write;
    logic        illegal;

    modport master (
        input  zero,
        input  mem_data,
        output instruction,
        output ctrl,
        output read,
        output write,
        output illegal
    );

    modport slave (
        output zero,
        output mem_data,
        input  instruction,
        input  ctrl,
        input  read,
        input  write,
        input  illegal
    );
endinterface

// File: rtl/cs147_control_unit.sv
// Multi-cycle control unit for the 32-bit cs147sec05 processor.
// Steps FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK for every instruction and
// drives the datapath control word plus memory READ/WRITE strobes.
// Optional feature macro: CS147_STACK_EN enables push (0x1b) and pop (0x1c); without it
// those opcodes decode as illegal NOPs.
module cs147_control_unit (
    input  logic                 clk,
    input  logic                 rst,
    cs147_control_unit_if.master bus
);

    // FSM state encoding
    localparam logic [2:0] StFetch     = 3'd0;
    localparam logic [2:0] StDecode    = 3'd1;
    localparam logic [2:0] StExecute   = 3'd2;
    localparam logic [2:0] StMemory    = 3'd3;
    localparam logic [2:0] StWriteback = 3'd4;

    // Control word bit positions
    localparam int unsigned BitPcLoad  = 0;
    localparam int unsigned BitPcSel1  = 1;
    localparam int unsigned BitPcSel2  = 2;
    localparam int unsigned BitPcSel3  = 3;
    localparam int unsigned BitR1Sel1  = 5;
    localparam int unsigned BitRegR    = 6;
    localparam int unsigned BitRegW    = 7;
    localparam int unsigned BitSpLoad  = 8;
    localparam int unsigned BitOp1Sel1 = 9;
    localparam int unsigned BitOp2Sel1 = 10;
    localparam int unsigned BitOp2Sel2 = 11;
    localparam int unsigned BitOp2Sel3 = 12;
    localparam int unsigned BitOp2Sel4 = 13;
    localparam int unsigned BitMaSel1  = 20;
    localparam int unsigned BitMaSel2  = 21;
    localparam int unsigned BitMdSel1  = 22;
    localparam int unsigned BitWdSel1  = 23;
    localparam int unsigned BitWdSel2  = 24;
    localparam int unsigned BitWdSel3  = 25;
    localparam int unsigned BitWaSel1  = 26;
    localparam int unsigned BitWaSel2  = 27;
    localparam int unsigned BitWaSel3  = 28;

    // ALU operation codes (control word [19:14])
    localparam logic [5:0] AluNone = 6'd0;
    localparam logic [5:0] AluAdd  = 6'd1;
    localparam logic [5:0] AluSub  = 6'd2;
    localparam logic [5:0] AluMul  = 6'd3;
    localparam logic [5:0] AluShr  = 6'd4;
    localparam logic [5:0] AluShl  = 6'd5;
    localparam logic [5:0] AluAnd  = 6'd6;
    localparam logic [5:0] AluOr   = 6'd7;
    localparam logic [5:0] AluNor  = 6'd8;
    localparam logic [5:0] AluSlt  = 6'd9;

    // Opcodes
    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJmp   = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0a;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpMuli  = 6'h1d;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
`ifdef CS147_STACK_EN
    localparam logic [5:0] OpPush  = 6'h1b;
    localparam logic [5:0] OpPop   = 6'h1c;
`endif

    // R-type funct codes
    localparam logic [5:0] FnSll = 6'h01;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2a;
    localparam logic [5:0] FnMul = 6'h2c;

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;

    // Per-instruction decode results
    logic [31:0] exec_w;   // operand selects, ALU op, pop SP update
    logic [31:0] mem_w;    // memory address/data selects
    logic [31:0] wb_w;     // register write selects
    logic [5:0]  alu;
    logic        r_alu;    // R-type op that writes rd from the ALU
    logic        legal;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_beq;
    logic        is_bne;
    logic        is_jump;
    logic        is_jr;
    logic        is_push;

    logic [31:0] ctrl;
    logic        read;
    logic        write;
    logic        illegal;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // State and instruction register; IR only loads at the close of FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch) begin
                ir_q <= bus.mem_data;
            end
        end
    end

    // Unconditional five-state sequence
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:     state_d = StDecode;
            StDecode:    state_d = StExecute;
            StExecute:   state_d = StMemory;
            StMemory:    state_d = StWriteback;
            StWriteback: state_d = StFetch;
            default:     state_d = StFetch;
        endcase
    end

    // Instruction decode from IR
    always_comb begin
        exec_w  = '0;
        mem_w   = '0;
        wb_w    = '0;
        alu     = AluNone;
        r_alu   = 1'b0;
        legal   = 1'b1;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jump = 1'b0;
        is_jr   = 1'b0;
        is_push = 1'b0;

        case (opcode)
            OpRType: begin
                case (funct)
                    FnAdd: begin alu = AluAdd; r_alu = 1'b1; end
                    FnSub: begin alu = AluSub; r_alu = 1'b1; end
                    FnMul: begin alu = AluMul; r_alu = 1'b1; end
                    FnAnd: begin alu = AluAnd; r_alu = 1'b1; end
                    FnOr:  begin alu = AluOr;  r_alu = 1'b1; end
                    FnNor: begin alu = AluNor; r_alu = 1'b1; end
                    FnSlt: begin alu = AluSlt; r_alu = 1'b1; end
                    FnSll: begin
                        alu                = AluShl;
                        wb_w[BitRegW]      = 1'b1;
                        wb_w[BitWdSel3]    = 1'b1;
                        wb_w[BitWaSel3]    = 1'b1;
                        exec_w[BitOp2Sel3] = 1'b1;
                        exec_w[BitOp2Sel1] = 1'b1;
                    end
                    FnSrl: begin
                        alu                = AluShr;
                        wb_w[BitRegW]      = 1'b1;
                        wb_w[BitWdSel3]    = 1'b1;
                        wb_w[BitWaSel3]    = 1'b1;
                        exec_w[BitOp2Sel3] = 1'b1;
                        exec_w[BitOp2Sel1] = 1'b1;
                    end
                    FnJr:    is_jr = 1'b1;
                    default: legal = 1'b0;
                endcase
                if (r_alu) begin
                    exec_w[BitOp2Sel4] = 1'b1;
                    wb_w[BitRegW]      = 1'b1;
                    wb_w[BitWdSel3]    = 1'b1;
                    wb_w[BitWaSel3]    = 1'b1;
                end
            end
            OpAddi, OpMuli, OpSlti, OpAndi, OpOri: begin
                case (opcode)
                    OpAddi:  alu = AluAdd;
                    OpMuli:  alu = AluMul;
                    OpSlti:  alu = AluSlt;
                    OpAndi:  alu = AluAnd;
                    default: alu = AluOr;
                endcase
                // andi/ori take the zero-extended immediate
                exec_w[BitOp2Sel2] = (opcode != OpAndi) && (opcode != OpOri);
                wb_w[BitRegW]      = 1'b1;
                wb_w[BitWdSel3]    = 1'b1;
                wb_w[BitWaSel1]    = 1'b1;
                wb_w[BitWaSel3]    = 1'b1;
            end
            OpLui: begin
                wb_w[BitRegW]   = 1'b1;
                wb_w[BitWdSel2] = 1'b1;
                wb_w[BitWdSel3] = 1'b1;
                wb_w[BitWaSel1] = 1'b1;
                wb_w[BitWaSel3] = 1'b1;
            end
            OpBeq, OpBne: begin
                alu                = AluSub;
                exec_w[BitOp2Sel4] = 1'b1;
                is_beq             = (opcode == OpBeq);
                is_bne             = (opcode == OpBne);
            end
            OpLw: begin
                alu                = AluAdd;
                exec_w[BitOp2Sel2] = 1'b1;
                mem_rd             = 1'b1;
                wb_w[BitRegW]      = 1'b1;
                wb_w[BitWdSel1]    = 1'b1;
                wb_w[BitWdSel3]    = 1'b1;
                wb_w[BitWaSel1]    = 1'b1;
                wb_w[BitWaSel3]    = 1'b1;
            end
            OpSw: begin
                alu                = AluAdd;
                exec_w[BitOp2Sel2] = 1'b1;
                mem_wr             = 1'b1;
            end
            OpJmp: is_jump = 1'b1;
            OpJal: begin
                // wd_sel_3=0 picks PC+1, wa_sel_3=0 with wa_sel_2=1 picks r31
                is_jump         = 1'b1;
                wb_w[BitRegW]   = 1'b1;
                wb_w[BitWaSel2] = 1'b1;
            end
`ifdef CS147_STACK_EN
            OpPush: begin
                // SP decrement happens in WRITEBACK, after the store
                is_push          = 1'b1;
                mem_wr           = 1'b1;
                mem_w[BitMaSel1] = 1'b1;
                mem_w[BitMdSel1] = 1'b1;
            end
            OpPop: begin
                // SP increments at the close of EXECUTE, then memory reads at the new SP
                alu                = AluAdd;
                exec_w[BitOp1Sel1] = 1'b1;
                exec_w[BitOp2Sel3] = 1'b1;
                exec_w[BitSpLoad]  = 1'b1;
                mem_rd             = 1'b1;
                mem_w[BitMaSel1]   = 1'b1;
                wb_w[BitRegW]      = 1'b1;
                wb_w[BitWdSel1]    = 1'b1;
                wb_w[BitWdSel3]    = 1'b1;
            end
`endif
            default: legal = 1'b0;
        endcase

        exec_w[19:14] = alu;
    end

    // Per-state control word and strobes; everything forced low while in reset
    always_comb begin
        ctrl    = '0;
        read    = 1'b0;
        write   = 1'b0;
        illegal = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    ctrl[BitMaSel2] = 1'b1;
                    read            = 1'b1;
                end
                StDecode: begin
                    ctrl[BitRegR]   = 1'b1;
                    ctrl[BitR1Sel1] = is_push;
                end
                StExecute: begin
                    ctrl            = exec_w;
                    ctrl[BitRegR]   = 1'b1;
                    ctrl[BitR1Sel1] = is_push;
                end
                StMemory: begin
                    ctrl            = exec_w | mem_w;
                    ctrl[BitSpLoad] = 1'b0;
                    ctrl[BitRegR]   = 1'b1;
                    ctrl[BitR1Sel1] = is_push;
                    read            = mem_rd;
                    write           = mem_wr;
                end
                StWriteback: begin
                    ctrl            = exec_w | mem_w | wb_w;
                    ctrl[BitSpLoad] = 1'b0;
                    ctrl[BitRegR]   = 1'b1;
                    ctrl[BitR1Sel1] = is_push;
                    ctrl[BitPcLoad] = 1'b1;
                    ctrl[BitPcSel1] = !is_jr;
                    ctrl[BitPcSel2] = (is_beq && bus.zero) || (is_bne && !bus.zero);
                    ctrl[BitPcSel3] = !is_jump;
                    if (is_push) begin
                        ctrl[BitOp1Sel1] = 1'b1;
                        ctrl[BitOp2Sel3] = 1'b1;
                        ctrl[BitOp2Sel1] = 1'b0;
                        ctrl[BitOp2Sel4] = 1'b0;
                        ctrl[19:14]      = AluSub;
                        ctrl[BitSpLoad]  = 1'b1;
                    end
                    illegal = !legal;
                end
                default: ;
            endcase
        end
    end

    assign bus.instruction = ir_q;
    assign bus.ctrl        = ctrl;
    assign bus.read        = read;
    assign bus.write       = write;
    assign bus.illegal     = illegal;

endmodule

// File: tb/tb_cs147_control_unit.sv
// Directed, table-driven bench for cs147_control_unit.
// Each vector runs one full 5-cycle instruction and compares the outputs in one state.
module tb_cs147_control_unit;

    // Control word bit masks
    localparam logic [31:0] PCL   = 32'h0000_0001;
    localparam logic [31:0] PS1   = 32'h0000_0002;
    localparam logic [31:0] PS2   = 32'h0000_0004;
    localparam logic [31:0] PS3   = 32'h0000_0008;
    localparam logic [31:0] R1S   = 32'h0000_0020;
    localparam logic [31:0] RR    = 32'h0000_0040;
    localparam logic [31:0] RW    = 32'h0000_0080;
    localparam logic [31:0] SPL   = 32'h0000_0100;
    localparam logic [31:0] OP1S  = 32'h0000_0200;
    localparam logic [31:0] OP2S1 = 32'h0000_0400;
    localparam logic [31:0] S2E   = 32'h0000_0800;
    localparam logic [31:0] OP2S3 = 32'h0000_1000;
    localparam logic [31:0] OP2R  = 32'h0000_2000;
    localparam logic [31:0] ADD   = 32'h0000_4000;
    localparam logic [31:0] SUB   = 32'h0000_8000;
    localparam logic [31:0] SHL   = 32'h0001_4000;
    localparam logic [31:0] AND   = 32'h0001_8000;
    localparam logic [31:0] MA1   = 32'h0010_0000;
    localparam logic [31:0] MA2   = 32'h0020_0000;
    localparam logic [31:0] MD1   = 32'h0040_0000;
    localparam logic [31:0] WD1   = 32'h0080_0000;
    localparam logic [31:0] WD2   = 32'h0100_0000;
    localparam logic [31:0] WD3   = 32'h0200_0000;
    localparam logic [31:0] WA1   = 32'h0400_0000;
    localparam logic [31:0] WA2   = 32'h0800_0000;
    localparam logic [31:0] WA3   = 32'h1000_0000;

    // Instructions
    localparam logic [31:0] I_ADDI = 32'h2022_0005;
    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SLL  = 32'h0022_1881;
    localparam logic [31:0] I_ANDI = 32'h3022_000F;
    localparam logic [31:0] I_BEQ  = 32'h1022_0004;
    localparam logic [31:0] I_BNE  = 32'h1422_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0003;
    localparam logic [31:0] I_LW   = 32'h8C22_0003;
    localparam logic [31:0] I_LUI  = 32'h3C01_1234;
    localparam logic [31:0] I_JMP  = 32'h0800_0010;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_BADO = 32'hFC00_0000;
    localparam logic [31:0] I_BADF = 32'h0000_003F;
    localparam logic [31:0] I_PUSH = 32'h6C00_0000;
    localparam logic [31:0] I_POP  = 32'h7000_0000;

    localparam logic [31:0] WB_BASE = RR | PCL | PS1 | PS3;

    typedef struct packed {
        logic [31:0] instr;
        logic        zero;
        logic [2:0]  st;     // 0 fetch .. 4 writeback
        logic [31:0] ctrl;
        logic        rd;
        logic        wr;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    cs147_control_unit_if bus ();

    cs147_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic zero, input logic [2:0] st,
                                input logic [31:0] ctrl, input logic rd, input logic wr,
                                input logic ill);
        vec_t v;
        v.instr = instr;
        v.zero  = zero;
        v.st    = st;
        v.ctrl  = ctrl;
        v.rd    = rd;
        v.wr    = wr;
        v.ill   = ill;
        return v;
    endfunction

    // Called #1 after a rising edge with the DUT in FETCH; returns in the same alignment.
    task automatic run_vec(input vec_t v, input string tag);
        for (int p = 0; p < 5; p++) begin
            bus.mem_data = (p == 0) ? v.instr : 32'hDEAD_BEEF;
            bus.zero     = v.zero;
            #1;
            if (p == int'(v.st)) begin
                check32({tag, " ctrl"}, bus.ctrl, v.ctrl);
                check1({tag, " read"}, bus.read, v.rd);
                check1({tag, " write"}, bus.write, v.wr);
                check1({tag, " illegal"}, bus.illegal, v.ill);
                if (p > 0) check32({tag, " instruction"}, bus.instruction, v.instr);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs.push_back(mk(I_ADDI, 1'b0, 3'd0, MA2, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(I_ADDI, 1'b0, 3'd1, RR, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_ADDI, 1'b0, 3'd2, RR | S2E | ADD, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_ADDI, 1'b0, 3'd4, WB_BASE | S2E | ADD | RW | WD3 | WA1 | WA3,
                          1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_ADD, 1'b0, 3'd2, RR | OP2R | ADD, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_ADD, 1'b1, 3'd4, WB_BASE | OP2R | ADD | RW | WD3 | WA3,
                          1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_SLL, 1'b0, 3'd2, RR | OP2S3 | OP2S1 | SHL, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_ANDI, 1'b0, 3'd3, RR | AND, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_ANDI, 1'b0, 3'd4, WB_BASE | AND | RW | WD3 | WA1 | WA3,
                          1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_BEQ, 1'b1, 3'd4, WB_BASE | OP2R | SUB | PS2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_BEQ, 1'b0, 3'd4, WB_BASE | OP2R | SUB, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_BNE, 1'b0, 3'd4, WB_BASE | OP2R | SUB | PS2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_BNE, 1'b1, 3'd4, WB_BASE | OP2R | SUB, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_SW, 1'b0, 3'd2, RR | S2E | ADD, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_SW, 1'b0, 3'd3, RR | S2E | ADD, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(I_SW, 1'b0, 3'd4, WB_BASE | S2E | ADD, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_LW, 1'b0, 3'd3, RR | S2E | ADD, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(I_LW, 1'b0, 3'd4, WB_BASE | S2E | ADD | RW | WD1 | WD3 | WA1 | WA3,
                          1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_LUI, 1'b0, 3'd4, WB_BASE | RW | WD2 | WD3 | WA1 | WA3,
                          1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_JMP, 1'b0, 3'd4, RR | PCL | PS1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_JAL, 1'b0, 3'd4, RR | PCL | PS1 | RW | WA2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_JR, 1'b0, 3'd4, RR | PCL | PS3, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_BADO, 1'b0, 3'd3, RR, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_BADO, 1'b0, 3'd4, WB_BASE, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(I_BADF, 1'b0, 3'd4, WB_BASE, 1'b0, 1'b0, 1'b1));
`ifdef CS147_STACK_EN
        vecs.push_back(mk(I_PUSH, 1'b0, 3'd1, RR | R1S, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_PUSH, 1'b0, 3'd3, RR | R1S | MA1 | MD1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(I_PUSH, 1'b0, 3'd4,
                          WB_BASE | R1S | MA1 | MD1 | OP1S | OP2S3 | SUB | SPL,
                          1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_POP, 1'b0, 3'd2, RR | OP1S | OP2S3 | ADD | SPL, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_POP, 1'b0, 3'd3, RR | OP1S | OP2S3 | ADD | MA1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(I_POP, 1'b0, 3'd4, WB_BASE | OP1S | OP2S3 | ADD | MA1 | RW | WD1 | WD3,
                          1'b0, 1'b0, 1'b0));
`else
        vecs.push_back(mk(I_PUSH, 1'b0, 3'd1, RR, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_PUSH, 1'b0, 3'd3, RR, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_PUSH, 1'b0, 3'd4, WB_BASE, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(I_POP, 1'b0, 3'd2, RR, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(I_POP, 1'b0, 3'd4, WB_BASE, 1'b0, 1'b0, 1'b1));
`endif

        // Reset: outputs held low while RST is high, IR cleared
        rst          = 1'b1;
        bus.zero     = 1'b0;
        bus.mem_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        check32("reset ctrl", bus.ctrl, 32'h0);
        check1("reset read", bus.read, 1'b0);
        check1("reset write", bus.write, 1'b0);
        check1("reset illegal", bus.illegal, 1'b0);
        check32("reset instruction", bus.instruction, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // RST during MEMORY of lw: outputs drop at once, then a clean FETCH with IR=0
        for (int p = 0; p < 3; p++) begin
            bus.mem_data = (p == 0) ? I_LW : 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
        end
        check1("lw mem read before reset", bus.read, 1'b1);
        rst = 1'b1;
        #1;
        check32("rst in mem ctrl", bus.ctrl, 32'h0);
        check1("rst in mem read", bus.read, 1'b0);
        check1("rst in mem write", bus.write, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check32("post-reset instruction", bus.instruction, 32'h0);
        check32("post-reset ctrl", bus.ctrl, MA2);
        check1("post-reset read", bus.read, 1'b1);
        @(posedge clk);
        #1;
        check32("post-reset decode ir", bus.instruction, 32'hDEAD_BEEF);
        // Finish this instruction (illegal opcode 0x37) and resume normal flow
        for (int p = 1; p < 5; p++) begin
            if (p == 4) check1("post-reset junk illegal", bus.illegal, 1'b1);
            @(posedge clk);
            #1;
        end
        run_vec(mk(I_ADDI, 1'b0, 3'd4, WB_BASE | S2E | ADD | RW | WD3 | WA1 | WA3,
                   1'b0, 1'b0, 1'b0), "resume addi");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
